// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel switch debouncer.
// Build option: DEBOUNCE_REPEAT_EN adds auto-repeat PRESS strobes on held switches.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_t;

  localparam int unsigned DEF_N_CH            = 16;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 10000000;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch: 2-flop synchroniser, 4-state filter FSM, run-length counter.
// Build option: DEBOUNCE_REPEAT_EN reuses the counter for auto-repeat while held high.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`ifdef DEBOUNCE_REPEAT_EN
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
`endif
  parameter int unsigned CNT_W           = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  input  logic i_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             r_sync1;
  logic             r_sync2;
  deb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_busy;

  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_s;

`ifdef DEBOUNCE_REPEAT_EN
  // Set once the first (long) repeat interval has elapsed; later ones use REPEAT_CYCLES.
  logic             r_rpt_armed;
  logic             w_rpt_armed_nxt;
`endif

  assign w_s       = r_sync2;
  assign w_cnt_inc = r_cnt + CNT_ONE;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
    w_rpt_armed_nxt = r_rpt_armed;
`endif
    if (i_en) begin
      case (r_state)
        STABLE_LO: begin
          if (w_s) begin
            w_state_nxt = WAIT_HI;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!w_s) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        STABLE_HI: begin
          if (!w_s) begin
            w_state_nxt = WAIT_LO;
            w_cnt_nxt   = CNT_ONE;
`ifdef DEBOUNCE_REPEAT_EN
            w_rpt_armed_nxt = 1'b0;
`endif
          end
`ifdef DEBOUNCE_REPEAT_EN
          else if (r_cnt == (r_rpt_armed ? RPT_NEXT_LAST : RPT_FIRST_LAST)) begin
            w_cnt_nxt       = '0;
            w_press_nxt     = 1'b1;
            w_rpt_armed_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
`endif
        end
        WAIT_LO: begin
          if (w_s) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt   = STABLE_LO;
            w_cnt_nxt     = '0;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= STABLE_LO;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_busy    <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      r_rpt_armed <= 1'b0;
`endif
    end else begin
      r_sync1   <= i_sw;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_busy    <= (w_state_nxt == WAIT_HI) || (w_state_nxt == WAIT_LO);
`ifdef DEBOUNCE_REPEAT_EN
      r_rpt_armed <= w_rpt_armed_nxt;
`endif
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_busy    = r_busy;

endmodule

// File: rtl/sw_debounce_multi.sv
// N_CH-wide switch debouncer: one debounce_channel per input, shared enable, OR-ed busy.
// Build option: DEBOUNCE_REPEAT_EN enables auto-repeat PRESS strobes in every channel.
module sw_debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH            = DEF_N_CH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] SW,
  input  logic            ENABLE,
  output logic [N_CH-1:0] SWOUT,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic            BUSY
);

  localparam int unsigned CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_CYCLES) + 1);

  logic [N_CH-1:0] w_busy;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef DEBOUNCE_REPEAT_EN
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
`endif
      .CNT_W           (CNT_W)
    ) u_ch (
      .i_clk     (CLK),
      .i_rst     (RESET),
      .i_sw      (SW[g]),
      .i_en      (ENABLE),
      .o_level   (SWOUT[g]),
      .o_press   (PRESS[g]),
      .o_release (RELEASE[g]),
      .o_busy    (w_busy[g])
    );
  end

  assign BUSY = |w_busy;

endmodule

// File: tb/tb_sw_debounce_multi.sv
// Self-checking bench for sw_debounce_multi (4 channels, 4-cycle debounce).
// Table vectors, hand-written corner sequences, then random stimulus against a run-length model.
module tb_sw_debounce_multi;

  localparam int NCH = 4;
  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RC  = 3;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic           ENABLE = 1'b0;
  logic [NCH-1:0] SW = '0;
  logic [NCH-1:0] SWOUT, PRESS, RELEASE;
  logic           BUSY;

  int n_vec = 0;
  int n_err = 0;
  bit use_model = 1'b0;

  // Reference model: level changes after DEB consecutive enabled samples that disagree with it.
  logic [NCH-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
  logic           m_busy;
  int             m_run[NCH];
  int             m_ht[NCH];

  typedef struct {
    logic [NCH-1:0] sw;
    logic           en;
    logic           rst;
    logic [NCH-1:0] swout;
    logic [NCH-1:0] press;
    logic [NCH-1:0] rel;
    logic           busy;
  } vec_t;

  vec_t tbl[$];

  sw_debounce_multi #(
    .N_CH            (NCH),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_CYCLES   (RC)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SW      (SW),
    .ENABLE  (ENABLE),
    .SWOUT   (SWOUT),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [NCH-1:0] sw, input logic en, input logic rst);
    logic [NCH-1:0] s;
    s       = m_s2;
    m_press = '0;
    m_rel   = '0;
    if (rst) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      for (int i = 0; i < NCH; i++) begin
        m_run[i] = 0;
        m_ht[i]  = 0;
      end
    end else begin
      if (en) begin
        for (int i = 0; i < NCH; i++) begin
          if (s[i] != m_lvl[i]) begin
            m_run[i]++;
            m_ht[i] = 0;
            if (m_run[i] == DEB) begin
              m_lvl[i] = s[i];
              m_run[i] = 0;
              if (s[i]) m_press[i] = 1'b1;
              else      m_rel[i]   = 1'b1;
            end
          end else if (m_run[i] != 0) begin
            m_run[i] = 0;
            m_ht[i]  = 0;
          end else if (m_lvl[i]) begin
            m_ht[i]++;
`ifdef DEBOUNCE_REPEAT_EN
            if (m_ht[i] == RD || (m_ht[i] > RD && (m_ht[i] - RD) % RC == 0))
              m_press[i] = 1'b1;
`endif
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
    m_busy = 1'b0;
    for (int i = 0; i < NCH; i++) if (m_run[i] != 0) m_busy = 1'b1;
  endtask

  task automatic step(input logic [NCH-1:0] sw, input logic en, input logic rst);
    @(negedge CLK);
    SW     = sw;
    ENABLE = en;
    RESET  = rst;
    @(posedge CLK);
    model_edge(sw, en, rst);
    #1;
    if (use_model) begin
      check("model_swout",   SWOUT,   m_lvl);
      check("model_press",   PRESS,   m_press);
      check("model_release", RELEASE, m_rel);
      check("model_busy",    BUSY,    m_busy);
      check("press_release_exclusive", PRESS & RELEASE, '0);
    end
  endtask

  function automatic void add(input logic [NCH-1:0] sw, input logic en, input logic rst,
                              input logic [NCH-1:0] swout, input logic [NCH-1:0] press,
                              input logic [NCH-1:0] rel, input logic busy);
    vec_t v;
    v.sw = sw; v.en = en; v.rst = rst;
    v.swout = swout; v.press = press; v.rel = rel; v.busy = busy;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [NCH-1:0] r_sw;

    // Single press on ch0, accepted on the 6th edge counting the sampling edge.
    add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 0);
    add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 1);
    add(4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 1);
    add(4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 1);
    add(4'h1, 1, 0, 4'h1, 4'h1, 4'h0, 0);
    add(4'h1, 1, 0, 4'h1, 4'h0, 4'h0, 0);
    // Glitch on ch1: three raw cycles high is one sample short.
    add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 0);
    add(4'h2, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h2, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h2, 1, 0, 4'h0, 4'h0, 4'h0, 1);
    add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 1);
    add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 1);
    add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    // All channels rise together, then ch1/ch3 fall together.
    add(4'hF, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(4'hF, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(4'hF, 1, 0, 4'h0, 4'h0, 4'h0, 1);
    add(4'hF, 1, 0, 4'h0, 4'h0, 4'h0, 1);
    add(4'hF, 1, 0, 4'h0, 4'h0, 4'h0, 1);
    add(4'hF, 1, 0, 4'hF, 4'hF, 4'h0, 0);
    add(4'h5, 1, 0, 4'hF, 4'h0, 4'h0, 0);
    add(4'h5, 1, 0, 4'hF, 4'h0, 4'h0, 0);
    add(4'h5, 1, 0, 4'hF, 4'h0, 4'h0, 1);
    add(4'h5, 1, 0, 4'hF, 4'h0, 4'h0, 1);
    add(4'h5, 1, 0, 4'hF, 4'h0, 4'h0, 1);
    add(4'h5, 1, 0, 4'h5, 4'h0, 4'hA, 0);
    add(4'h5, 1, 0, 4'h5, 4'h0, 4'h0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sw, tbl[i].en, tbl[i].rst);
      check($sformatf("tbl%0d_swout", i),   SWOUT,   tbl[i].swout);
      check($sformatf("tbl%0d_press", i),   PRESS,   tbl[i].press);
      check($sformatf("tbl%0d_release", i), RELEASE, tbl[i].rel);
      check($sformatf("tbl%0d_busy", i),    BUSY,    tbl[i].busy);
    end

    use_model = 1'b1;

    // Freeze in the middle of WAIT_HI, then resume.
    step(4'h0, 1, 1);
    step(4'h0, 1, 1);
    for (int k = 0; k < 4; k++) step(4'h1, 1, 0);
    check("frz_busy_before", BUSY, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(4'h1, 0, 0);
      check("frz_swout", SWOUT, 4'h0);
      check("frz_press", PRESS, 4'h0);
      check("frz_busy",  BUSY,  1'b1);
    end
    step(4'h1, 1, 0);
    check("frz_resume1_swout", SWOUT, 4'h0);
    step(4'h1, 1, 0);
    check("frz_resume2_swout", SWOUT, 4'h1);
    check("frz_resume2_press", PRESS, 4'h1);

    // Reset while ch2 is accepted high and still held.
    step(4'h0, 1, 1);
    for (int k = 1; k <= 6; k++) step(4'h4, 1, 0);
    check("rst_pre_swout", SWOUT, 4'h4);
    check("rst_pre_press", PRESS, 4'h4);
    step(4'h4, 1, 1);
    check("rst_swout", SWOUT, 4'h0);
    check("rst_press", PRESS, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      step(4'h4, 1, 0);
      check($sformatf("rst_repress%0d", k), PRESS, (k == 6) ? 4'h4 : 4'h0);
    end

`ifdef DEBOUNCE_REPEAT_EN
    // Auto-repeat: accept at edge 6, repeats at +8, +11, +14, release sampled at edge 21.
    step(4'h0, 1, 1);
    for (int k = 1; k <= 28; k++) begin
      step((k < 21) ? 4'h1 : 4'h0, 1, 0);
      check($sformatf("rpt_press%0d", k), PRESS,
            (k == 6 || k == 14 || k == 17 || k == 20) ? 4'h1 : 4'h0);
      check($sformatf("rpt_release%0d", k), RELEASE, (k == 26) ? 4'h1 : 4'h0);
    end
`endif

    // Random stimulus against the model.
    step(4'h0, 1, 1);
    r_sw = '0;
    for (int n = 0; n < 1200; n++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 7) == 0) r_sw[i] = ~r_sw[i];
      if ($urandom_range(0, 99) < 3) r_sw = '1;
      step(r_sw, ($urandom_range(0, 15) != 0), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sw_debounce_multi.md
Name: sw_debounce_multi

Overview:
Parametrised multi-channel switch debouncer, next generation of the single FSM debouncer.
- Each of N_CH raw switch inputs is synchronised, then filtered by its own state machine and integrated counter. No external counter handshake (former CUENTAENA/CUENTADONE) is needed.
- Outputs are a debounced level plus one-cycle press/release strobes per channel.
- Sits between board switches/buttons and the Booth multiplier operand/control logic.

Parameters:
N_CH, 16, number of independent switch channels (1..32)
DEBOUNCE_CYCLES, 1000, consecutive stable synchronised samples required to accept a change (>=2)
REPEAT_DELAY, 50000000, cycles a level must be held high before the first auto-repeat strobe (used only with DEBOUNCE_REPEAT_EN)
REPEAT_CYCLES, 10000000, cycles between subsequent auto-repeat strobes (used only with DEBOUNCE_REPEAT_EN)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
SW  in  N_CH  raw asynchronous switch inputs
ENABLE  in  1  1 = filters run; 0 = every channel frozen (state, counter, SWOUT held; strobes forced 0)
SWOUT  out  N_CH  debounced level per channel
PRESS  out  N_CH  one-cycle strobe on accepted 0->1 (and on auto-repeat when enabled)
RELEASE  out  N_CH  one-cycle strobe on accepted 1->0
BUSY  out  1  OR of all channels currently in a WAIT state

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, RESET; sampled on rising edge of CLK.
- Reset values:
  - SWOUT=0, PRESS=0, RELEASE=0, BUSY=0.
  - All synchroniser flops=0, all counters=0, all channel states=STABLE_LO.
- Synchroniser: 2 flops per channel; s = second-flop output.
- Per-channel FSM:
  - STABLE_LO: s=1 -> WAIT_HI, cnt<=1; else stay.
  - WAIT_HI: s=0 -> STABLE_LO, cnt<=0 (glitch rejected, no strobe).
  - WAIT_HI: s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, SWOUT<=1, PRESS pulses 1 cycle.
  - WAIT_HI: otherwise cnt++.
  - STABLE_HI: s=0 -> WAIT_LO, cnt<=1; else stay.
  - WAIT_LO: mirror of WAIT_HI, ending in STABLE_LO with SWOUT<=0 and a 1-cycle RELEASE pulse.
- Latency: a clean raw edge, held steady, appears on SWOUT exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it. Strobes coincide with the SWOUT change cycle.
- Counter width: CNT_W=$clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_CYCLES)+1). The counter never wraps; it is bounded by the compare.
- Channels are fully independent. Simultaneous transitions on any subset all complete in the same cycle.
- PRESS and RELEASE are never both 1 on one channel in the same cycle.
- ENABLE=0 mid-WAIT: counter and state hold. Counting resumes on ENABLE=1 with the current s.
- RESET mid-WAIT: the channel returns to STABLE_LO with no strobe, even if SW is held high. A held-high switch is re-accepted as a fresh PRESS after 2+DEBOUNCE_CYCLES cycles.
- BUSY is registered from next-state (it reflects the WAIT states of the same cycle as SWOUT).

Optional Feature:
Macro: DEBOUNCE_REPEAT_EN.
- Defined:
  - In STABLE_HI, cnt runs from 0.
  - At cnt==REPEAT_DELAY-1, PRESS pulses and cnt reloads 0.
  - Thereafter PRESS pulses every REPEAT_CYCLES while the channel stays STABLE_HI.
  - Any exit to WAIT_LO cancels repeat.
- Not defined: no repeat logic or comparators; PRESS pulses only on accepted rising edges; REPEAT_* are unused.

Decomposition:
- Package debounce_pkg:
  - deb_state_t enum {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} (2-bit).
  - Default constants for DEBOUNCE_CYCLES/REPEAT_*.
  - A max3 function for CNT_W.
- Sub-module debounce_channel (synchroniser + FSM + counter for one bit), instantiated N_CH times in a generate loop.
- The top level handles only ENABLE fan-out and the BUSY reduction.

Test Plan:
1. N_CH=4, DEBOUNCE_CYCLES=4: RESET 2 cycles, SW=4'b0001 held -> SWOUT[0] rises exactly 6 edges later, PRESS[0] one cycle at the same edge, BUSY high during the 3 preceding cycles.
2. Glitch: SW[1] high for 3 cycles then low -> SWOUT[1] stays 0, no PRESS/RELEASE, BUSY returns 0.
3. Simultaneous: SW 4'b0000->4'b1111 -> all SWOUT bits and all 4 PRESS bits assert in the same cycle; later 4'b1111->4'b0101 -> RELEASE=4'b1010 for exactly one cycle.
4. Freeze: ENABLE=0 after 2 cycles in WAIT_HI, hold 10 cycles, ENABLE=1 -> SWOUT rises 2 cycles after re-enable, no strobes while frozen.
5. Reset mid-operation: RESET asserted while SWOUT[2]=1 and SW[2] still high -> SWOUT=0 next edge; after release, PRESS[2] reasserts 6 cycles later.
6. DEBOUNCE_REPEAT_EN, REPEAT_DELAY=8, REPEAT_CYCLES=3: hold SW[0] -> PRESS[0] at accept, +8, +11, +14 cycles; release SW[0] -> repeats stop, one RELEASE[0].
